// File: rtl/add16_result_stage_if.sv
// Result-stream interface between the adder, the result stage and its consumer.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1; the master holds valid and the payload stable until that edge, and
// ready may be asserted independently of valid.
interface add16_result_stage_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (output valid, output sum, output cout, output overflow, input ready);
  modport slave  (input valid, input sum, input cout, input overflow, output ready);
endinterface

// File: rtl/add16_result_stage.sv
// Registered 2-entry output buffer behind the 16-bit adder. It cuts the carry
// path, applies back-pressure and keeps sticky/saturating overflow statistics.
module add16_result_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  add16_result_stage_if.slave  in_if,
  add16_result_stage_if.master out_if,
  input  logic                 clr_sticky,
  output logic                 sticky_ovf,
  output logic [CNT_W-1:0]     ovf_count
);

  localparam int EW = WIDTH + 2;  // {sum, cout, overflow}
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       occ_q, occ_d;
  logic [EW-1:0]    head_q, head_d;
  logic [EW-1:0]    tail_q, tail_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          push, pop;
  logic [EW-1:0] in_entry;

  // Ready and valid come from occupancy only, so no combinational path crosses the stage.
  assign in_if.ready  = (occ_q != OCC_FULL);
  assign out_if.valid = (occ_q != OCC_EMPTY);
  assign {out_if.sum, out_if.cout, out_if.overflow} = head_q;

  assign push     = in_if.valid & in_if.ready;
  assign pop      = out_if.valid & out_if.ready;
  assign in_entry = {in_if.sum, in_if.cout, in_if.overflow};

  // Buffer next state: head is what the consumer sees, tail is the second slot.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d = in_entry;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          tail_d = in_entry;
          occ_d  = OCC_FULL;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  // Overflow statistics: a set from an accepted beat beats a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (push && in_if.overflow) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (push && in_if.overflow && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset empties the buffer and zeroes the visible head.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= OCC_EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky_ovf = sticky_q;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_add16_result_stage.sv
// Bench for add16_result_stage: directed vector table, hand sequences and
// random traffic, all compared against a queue-based model of the stage.
module tb_add16_result_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_sticky = 1'b0;
  always #5 clk = ~clk;

  add16_result_stage_if #(.WIDTH(16)) in_if ();
  add16_result_stage_if #(.WIDTH(16)) out_if ();
  add16_result_stage_if #(.WIDTH(16)) in2_if ();
  add16_result_stage_if #(.WIDTH(16)) out2_if ();

  logic       sticky_ovf, sticky2;
  logic [7:0] ovf_count;
  logic [1:0] ovf_count2;

  add16_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_if(in_if.slave), .out_if(out_if.master),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
  );

  // Narrow-counter copy fed with identical traffic for the saturation checks.
  add16_result_stage #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_if(in2_if.slave), .out_if(out2_if.master),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky2), .ovf_count(ovf_count2)
  );
  assign in2_if.valid    = in_if.valid;
  assign in2_if.sum      = in_if.sum;
  assign in2_if.cout     = in_if.cout;
  assign in2_if.overflow = in_if.overflow;
  assign out2_if.ready   = out_if.ready;

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];      // buffered beats {sum, cout, ovf}, head first
  logic [17:0] shown = '0;    // what out_* should display
  logic        m_sticky = 1'b0;
  int          m_n = 0;       // accepted beats with overflow=1 since reset

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic model_check();
    check("in_ready", 32'(in_if.ready), 32'(exp_q.size() < 2));
    check("out_valid", 32'(out_if.valid), 32'(exp_q.size() > 0));
    check("out_payload", 32'({out_if.sum, out_if.cout, out_if.overflow}), 32'(shown));
    check("sticky", 32'(sticky_ovf), 32'(m_sticky));
    check("count8", 32'(ovf_count), 32'(sat(m_n, 255)));
    check("count2", 32'(ovf_count2), 32'(sat(m_n, 3)));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drives one cycle, advances the model at the
  // rising edge, then checks at the next falling edge.
  task automatic cycle(input logic v, input logic [15:0] s, input logic co, input logic ov,
                       input logic ordy, input logic clr, input logic r);
    bit push, pop;
    in_if.valid    = v;
    in_if.sum      = s;
    in_if.cout     = co;
    in_if.overflow = ov;
    out_if.ready   = ordy;
    clr_sticky     = clr;
    rst            = r;
    push = v && (exp_q.size() < 2);
    pop  = (exp_q.size() > 0) && ordy;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      shown    = '0;
      m_sticky = 1'b0;
      m_n      = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({s, co, ov});
      if (push && ov) begin
        m_sticky = 1'b1;
        m_n++;
      end else if (clr) begin
        m_sticky = 1'b0;
      end
      if (exp_q.size() > 0) shown = exp_q[0];
    end
    @(negedge clk);
    model_check();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic [15:0] s;
    logic        co, ov, ordy, clr;
    logic        e_ov;
    logic [15:0] e_sum;
    logic        e_co, e_ir, e_st;
    int          e_cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    in_if.valid = 1'b0; in_if.sum = '0; in_if.cout = 1'b0; in_if.overflow = 1'b0;
    out_if.ready = 1'b0;

    //        v  sum       co ov rdy clr | ov  sum       co ir st cnt
    tbl[0]  = '{1, 16'h1234, 0, 0, 1, 0,   1, 16'h1234, 0, 1, 0, 0};  // single beat
    tbl[1]  = '{0, 16'h0000, 0, 0, 1, 0,   0, 16'h1234, 0, 1, 0, 0};  // drained, head held
    tbl[2]  = '{1, 16'h0001, 0, 0, 0, 0,   1, 16'h0001, 0, 1, 0, 0};  // back-pressure fill
    tbl[3]  = '{1, 16'h0002, 0, 0, 0, 0,   1, 16'h0001, 0, 0, 0, 0};  // full
    tbl[4]  = '{1, 16'h0003, 0, 0, 0, 0,   1, 16'h0001, 0, 0, 0, 0};  // refused, held
    tbl[5]  = '{1, 16'h0003, 0, 0, 1, 0,   1, 16'h0002, 0, 1, 0, 0};  // pop only
    tbl[6]  = '{1, 16'h0003, 0, 0, 1, 0,   1, 16'h0003, 0, 1, 0, 0};  // push+pop at 1
    tbl[7]  = '{0, 16'h0000, 0, 0, 1, 0,   0, 16'h0003, 0, 1, 0, 0};
    tbl[8]  = '{1, 16'h8000, 0, 1, 1, 0,   1, 16'h8000, 0, 1, 1, 1};  // 0x4000+0x4000
    tbl[9]  = '{1, 16'h7FFF, 1, 1, 1, 0,   1, 16'h7FFF, 1, 1, 1, 2};  // 0x8000+0xFFFF
    tbl[10] = '{1, 16'h0000, 0, 0, 1, 0,   1, 16'h0000, 0, 1, 1, 2};
    tbl[11] = '{0, 16'h0000, 0, 0, 1, 1,   0, 16'h0000, 0, 1, 0, 2};  // clear sticky
    tbl[12] = '{1, 16'h8000, 0, 1, 1, 1,   1, 16'h8000, 0, 1, 1, 3};  // set beats clear
    tbl[13] = '{0, 16'h0000, 0, 0, 1, 0,   0, 16'h8000, 0, 1, 1, 3};

    @(negedge clk);
    cycle(0, 16'h0, 0, 0, 0, 0, 1);
    cycle(0, 16'h0, 0, 0, 0, 0, 1);
    // reset state
    check("rst_out_valid", 32'(out_if.valid), 32'd0);
    check("rst_out_sum", 32'(out_if.sum), 32'd0);
    check("rst_in_ready", 32'(in_if.ready), 32'd1);
    cycle(0, 16'h0, 0, 0, 0, 0, 0);
    check("idle_in_ready", 32'(in_if.ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].ordy, tbl[i].clr, 0);
      check($sformatf("tbl%0d_out_valid", i), 32'(out_if.valid), 32'(tbl[i].e_ov));
      check($sformatf("tbl%0d_out_sum", i), 32'(out_if.sum), 32'(tbl[i].e_sum));
      check($sformatf("tbl%0d_out_cout", i), 32'(out_if.cout), 32'(tbl[i].e_co));
      check($sformatf("tbl%0d_in_ready", i), 32'(in_if.ready), 32'(tbl[i].e_ir));
      check($sformatf("tbl%0d_sticky", i), 32'(sticky_ovf), 32'(tbl[i].e_st));
      check($sformatf("tbl%0d_count", i), 32'(ovf_count), 32'(tbl[i].e_cnt));
    end

    // Streaming: 10 back-to-back beats, each visible one cycle later.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 16'(i), 0, 0, 1, 0, 0);
      check("stream_in_ready", 32'(in_if.ready), 32'd1);
      check("stream_out_sum", 32'(out_if.sum), 32'(i));
      check("stream_out_valid", 32'(out_if.valid), 32'd1);
    end
    cycle(0, 16'h0, 0, 0, 1, 0, 0);
    check("stream_drained", 32'(out_if.valid), 32'd0);

    // Saturation: two more overflow beats (5 total) pin the 2-bit counter at 3.
    cycle(1, 16'hAAAA, 1, 1, 1, 0, 0);
    cycle(1, 16'h5555, 0, 1, 1, 0, 0);
    cycle(0, 16'h0, 0, 0, 1, 0, 0);
    check("sat_count2", 32'(ovf_count2), 32'd3);
    check("sat_count8", 32'(ovf_count), 32'd5);

    // Reset with the buffer full and sticky set.
    cycle(1, 16'h1111, 0, 1, 0, 0, 0);
    cycle(1, 16'h2222, 0, 0, 0, 0, 0);
    check("pre_rst_full", 32'(in_if.ready), 32'd0);
    cycle(1, 16'h3333, 0, 0, 0, 0, 1);
    check("mid_rst_out_valid", 32'(out_if.valid), 32'd0);
    check("mid_rst_out_sum", 32'(out_if.sum), 32'd0);
    check("mid_rst_sticky", 32'(sticky_ovf), 32'd0);
    check("mid_rst_count", 32'(ovf_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_if.ready), 32'd1);
    cycle(1, 16'hBEEF, 1, 0, 1, 0, 0);
    check("post_rst_sum", 32'(out_if.sum), 32'hBEEF);
    check("post_rst_cout", 32'(out_if.cout), 32'd1);
    cycle(0, 16'h0, 0, 0, 1, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add16_result_stage.md
Name: add16_result_stage

Overview:
Registered, back-pressured output stage directly downstream of the 16-bit ripple-carry adder. Captures each adder result (sum, cout, overflow) on a valid/ready handshake into a 2-entry buffer and presents it to the consumer. Tracks overflow statistics: a sticky flag and a saturating count. Breaks the long combinational carry path from the adder before any downstream logic.

Parameters:
WIDTH, 16, data width of sum; must match the adder's WIDTH
CNT_W, 8, width of the saturating overflow counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept a result this cycle
in_sum  input  WIDTH  adder sum
in_cout  input  1  adder carry out
in_overflow  input  1  adder signed overflow
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_sum  output  WIDTH  head entry sum
out_cout  output  1  head entry carry
out_overflow  output  1  head entry overflow
clr_sticky  input  1  clear sticky_ovf
sticky_ovf  output  1  set once any accepted beat had overflow=1
ovf_count  output  CNT_W  number of accepted beats with overflow=1, saturating

Behaviour:
- Reset (rst=1 at a clk edge): occupancy=0, out_valid=0, out_sum=0, out_cout=0, out_overflow=0, sticky_ovf=0, ovf_count=0, in_ready=1 on the following cycle. Reset mid-transfer discards all buffered entries. No beat is accepted in a reset cycle.
- Storage: 2-entry FIFO of {sum, cout, overflow}. Occupancy register takes values 0, 1, 2.
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- in_ready = (occupancy != 2). It is a function of registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = (occupancy != 0). out_* come directly from the head register, with no combinational path from in_* to out_*.
- Latency: a beat pushed at edge N into an empty stage appears on out_* with out_valid=1 in cycle N+1, i.e. one cycle.
- Occupancy transitions:
  - push only: +1.
  - pop only: -1.
  - push & pop: unchanged. With occupancy 1, the new beat becomes head on the next cycle. With occupancy 2, no push is possible.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- Hold rule: while out_valid=1 and out_ready=0, out_sum, out_cout and out_overflow stay stable.
- When empty, out_* hold their last value. Only out_valid is meaningful.
- Sticky flag:
  - Set on a push with in_overflow=1.
  - clr_sticky=1 clears it.
  - If a set and a clear occur in the same cycle, set wins (sticky_ovf=1).
- ovf_count increments by 1 on each push with in_overflow=1. It holds at 2^CNT_W-1 (no wrap). Only rst clears it; clr_sticky does not.
- in_cout is carried through only. It has no effect on the statistics.

Test Plan:
- Single beat: push {sum=0x1234, cout=0, ovf=0} into an empty stage with out_ready=1 -> the next cycle shows out_valid=1, out_sum=0x1234. The cycle after that shows out_valid=0. sticky_ovf=0, ovf_count=0.
- Back-pressure: out_ready=0, push 0x0001, 0x0002, 0x0003 on consecutive cycles -> in_ready drops after two pushes and the third is not accepted (held by upstream). out_sum stays 0x0001. Raising out_ready then yields 0x0001, 0x0002, 0x0003 in order.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles with sums 0..9 -> in_ready stays 1, outputs appear 0..9 one cycle delayed, occupancy never exceeds 1.
- Overflow stats: push 0x8000/ovf=1 (from 0x4000+0x4000), then 0x7FFF/ovf=1 (from 0x8000+0xFFFF), then 0x0000/ovf=0 -> ovf_count=2 and sticky_ovf=1. Pulsing clr_sticky clears the flag while ovf_count stays 2. Pulsing clr_sticky in the same cycle as a push with ovf=1 -> sticky_ovf=1.
- Saturation: with CNT_W=2, push 5 beats with ovf=1 -> ovf_count=3.
- Reset mid-operation: with occupancy=2 and sticky_ovf=1, assert rst for one cycle -> out_valid=0, out_sum=0, sticky_ovf=0, ovf_count=0, in_ready=1 afterwards. The next push emerges correctly.
